rysy_mem_arbiter: RTL and testbench
===================================

# rysy_mem_arbiter

Two-master arbiter sharing the single-port instruction/data memory between `rysy_core` (master 0) and the program loader/debug port (master 1). Each cycle it grants the memory to at most one master, muxes that master's request onto the memory bus, and returns the read data one cycle later to the master that issued it. Arbitration is round-robin with bounded bursts. A continuously requesting master holds the memory for at most `MAX_HOLD` consecutive cycles while the other master is waiting.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width. Must be a multiple of 8.
- `MAX_HOLD`, 4, maximum consecutive grants to one master while the other requests. Must be ≥1.

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request, per master.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_be`, `m1_be`  in  DATA_W/8  byte enables.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data.
- `m0_rvalid`, `m1_rvalid`  out  1  the rdata presented this cycle answers the previous granted read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, one-cycle latency.

## Operation
- **State:**
  - `last_q`: index of the last granted master. Reset value 1, so master 0 wins the first tie.
  - `hold_q`: consecutive-grant count. Width clog2(MAX_HOLD+1); reset value 0.
  - `rv_q[1:0]`: pending read-valid, one bit per master. Reset value 0.
- **Grant decision** (combinational, same cycle as req):
  - No requests: no grant; `hold_q` ← 0.
  - One request: grant that master.
  - Both requesting, `hold_q`≠0 (previous cycle granted `last_q`) and `hold_q` < MAX_HOLD: grant `last_q`.
  - Both requesting, otherwise: grant the master ≠ `last_q`.
- **Counter update on a grant to master g:**
  - If g == `last_q` and `hold_q`≠0: `hold_q` ← min(`hold_q`+1, MAX_HOLD).
  - Otherwise `hold_q` ← 1.
  - In both cases `last_q` ← g.
- **Memory mux:**
  - Granted master's addr/wdata/we/be drive `mem_*`.
  - With no grant, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- **Read return:**
  - A granted read (we=0) sets `rv_q[g]` for exactly one cycle.
  - Writes never produce rvalid.
  - `m0_rdata` and `m1_rdata` are both `mem_rdata` unconditionally; masters qualify the data with their own rvalid.
- **Reset:** while `rst`=1, both gnt = 0, `mem_we`=0 and `mem_be`=0 (grant forced off), whatever the request inputs.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req, `last_q` and `hold_q`.
- Read latency is 1 cycle: for a read granted in cycle N, rvalid is high in cycle N+1 with `mem_rdata`.
- Back-to-back reads are supported: rvalid may be high every cycle.
- A master switch in cycle N+1 does not disturb the rvalid for cycle N.
- Handshake rules:
  - A master keeps req and its request fields stable until it sees gnt.
  - A denied request is not queued; it is re-arbitrated next cycle.
- Starvation bound: a waiting master is granted within MAX_HOLD cycles of asserting req.
- MAX_HOLD = 1 gives strict alternation under contention.
- Reset mid-operation:
  - Any in-flight `rv_q` is cleared; the read issued in the cycle before reset gets no rvalid.
  - The state returns to reset values on the first edge with `rst`=1.
- Write then read of the same address in consecutive cycles: the read returns the new data (memory property). The arbiter adds no reordering.

## Structure
- Package `rysy_bus_pkg`:
  - `mst_idx_t` (1-bit master index).
  - `mem_req_t` struct {addr, wdata, we, be}.
  - Constants `MST_CORE`=0 and `MST_LOAD`=1.
- One sub-module, `rysy_arb_pick`: the combinational grant decision. Inputs: req[1:0], `last_q`, `hold_q`, MAX_HOLD. Outputs: gnt[1:0], `nxt_last`, `nxt_hold`.
- Registers, request mux and read-return pipeline stay in `rysy_mem_arbiter`.

## Test plan
- **Reset:** `rst`=1 with both req high → both gnt=0, `mem_we`=0, `mem_be`=0. After release, first tie → `m0_gnt`=1.
- **Single read:** `m0_req`=1, we=0, addr=0x10, `mem_rdata`=0x00500113 next cycle → `m0_rvalid`=1 for one cycle with that data; `m1_rvalid` stays 0.
- **Contention burst, MAX_HOLD=4, both req held high 12 cycles:**
  - Grant sequence: m0 ×4, m1 ×4, m0 ×4.
  - `hold_q` reads 1,2,3,4 at each switch.
- **Writes produce no rvalid:** `m1_req`, we=1, be=4'b0011, addr=0x20, wdata=0xDEADBEEF.
  - `mem_we`=1, `mem_be`=4'b0011 and `mem_wdata`=0xDEADBEEF in the same cycle.
  - No rvalid on either port next cycle.
- **Reset mid-read:** m0 read granted in cycle N, `rst`=1 in cycle N+1 → `m0_rvalid`=0 in N+1 and `last_q`=1, `hold_q`=0 afterwards.

Source files
------------

// File: rtl/rysy_mem_arbiter_pkg.sv
// rysy_bus_pkg: shared master index, request record and master identifiers for the memory arbiter
package rysy_bus_pkg;
   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   typedef logic mst_idx_t;
   typedef struct packed {
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W-1:0]   wdata;
      logic                    we;
      logic [BUS_DATA_W/8-1:0] be;
   } mem_req_t;
   localparam mst_idx_t MST_CORE = 1'b0;
   localparam mst_idx_t MST_LOAD = 1'b1;
endpackage

// File: rtl/rysy_mem_arbiter_if.sv
// rysy_mem_arbiter_if: bus bundle between the two masters, the arbiter and the memory
//   m0_*/m1_* : per-master req/addr/wdata/we/be in, gnt/rdata/rvalid out
//   mem_*     : muxed request out to memory, mem_rdata back (one-cycle latency)
//   slave     : arbiter view; master : view of the masters and memory around it
interface rysy_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic                  m0_req, m1_req, m0_we, m1_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
   logic [ADDR_W-1:0]     m0_addr, m1_addr, mem_addr;
   logic [DATA_W-1:0]     m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
   logic [DATA_W/8-1:0]   m0_be, m1_be, mem_be;
   modport slave (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, m0_be, m1_be, mem_rdata,
      output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, mem_addr, mem_wdata, mem_we, mem_be
   );
   modport master (
      output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, m0_be, m1_be, mem_rdata,
      input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, mem_addr, mem_wdata, mem_we, mem_be
   );
endinterface

// File: rtl/rysy_mem_arbiter_pick.sv
// rysy_arb_pick: combinational round-robin grant decision with bounded bursts
//   req[1:0], last_q, hold_q in; gnt[1:0] (one-hot or zero), nxt_last, nxt_hold out
module rysy_arb_pick
   import rysy_bus_pkg::*;
#(
   parameter  int MAX_HOLD = 4,
   localparam int HW = $clog2(MAX_HOLD + 1)
) (
   input  logic [1:0]    req,
   input  mst_idx_t      last_q,
   input  logic [HW-1:0] hold_q,
   output logic [1:0]    gnt,
   output mst_idx_t      nxt_last,
   output logic [HW-1:0] nxt_hold
);
   logic     stay;
   mst_idx_t g;
   always_comb begin
      stay     = hold_q != '0 && hold_q < HW'(MAX_HOLD);
      g        = &req ? (stay ? last_q : ~last_q) : req[1];
      gnt      = |req ? (g ? 2'b10 : 2'b01) : 2'b00;
      nxt_last = |req ? g : last_q;
      nxt_hold = !(|req) ? '0 :
                 (g == last_q && hold_q != '0) ? (hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + 1'b1) :
                 HW'(1);
   end
endmodule

// File: rtl/rysy_mem_arbiter.sv
// rysy_mem_arbiter: two-master round-robin arbiter for the shared single-port memory
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave view of rysy_mem_arbiter_if (master requests, memory side, read return)
module rysy_mem_arbiter
   import rysy_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input logic               clk,
   input logic               rst,
   rysy_mem_arbiter_if.slave bus
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   mst_idx_t      last_q, nxt_last;
   logic [HW-1:0] hold_q, nxt_hold;
   logic [1:0]    rv_q, pick, gnt;
   rysy_arb_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
      .req      ({bus.m1_req, bus.m0_req}),
      .last_q   (last_q),
      .hold_q   (hold_q),
      .gnt      (pick),
      .nxt_last (nxt_last),
      .nxt_hold (nxt_hold)
   );
   assign gnt = rst ? 2'b00 : pick;
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= MST_LOAD;
         hold_q <= '0;
         rv_q   <= '0;
      end else begin
         last_q <= nxt_last;
         hold_q <= nxt_hold;
         rv_q   <= gnt & ~{bus.m1_we, bus.m0_we};
      end
   end
   assign bus.m0_gnt    = gnt[MST_CORE];
   assign bus.m1_gnt    = gnt[MST_LOAD];
   assign bus.mem_addr  = gnt[MST_LOAD] ? bus.m1_addr  : gnt[MST_CORE] ? bus.m0_addr  : '0;
   assign bus.mem_wdata = gnt[MST_LOAD] ? bus.m1_wdata : gnt[MST_CORE] ? bus.m0_wdata : '0;
   assign bus.mem_we    = gnt[MST_LOAD] ? bus.m1_we    : gnt[MST_CORE] & bus.m0_we;
   assign bus.mem_be    = gnt[MST_LOAD] ? bus.m1_be    : gnt[MST_CORE] ? bus.m0_be    : '0;
   assign bus.m0_rdata  = bus.mem_rdata;
   assign bus.m1_rdata  = bus.mem_rdata;
   // a read granted just before reset must not surface while rst is high
   assign bus.m0_rvalid = rv_q[MST_CORE] & ~rst;
   assign bus.m1_rvalid = rv_q[MST_LOAD] & ~rst;
endmodule

// File: tb/tb_rysy_mem_arbiter.sv
// tb_rysy_mem_arbiter: table, directed and randomized checks of rysy_mem_arbiter against a history-based model
module tb_rysy_mem_arbiter;
   localparam int AW = 32, DW = 32, MH = 4;
   typedef struct {
      logic       r;
      logic [1:0] req;
      logic [1:0] gnt;
      int         hold;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   int   vecs = 0, bad = 0;
   int   hist[$];
   int   exp_rv[2];
   int   cur_g;
   logic cur_we0, cur_we1;
   vec_t tab[19];
   always #5 clk = ~clk;
   rysy_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   rysy_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      vecs++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endfunction

   // most recent granted master since reset, 1 if none
   function automatic int m_last();
      for (int i = hist.size() - 1; i >= 0; i--) if (hist[i] >= 0) return hist[i];
      return 1;
   endfunction

   // length of the unbroken run of grants to the same master ending last cycle, capped at MH
   function automatic int m_streak();
      int n = 0;
      if (hist.size() == 0 || hist[hist.size()-1] < 0) return 0;
      for (int i = hist.size() - 1; i >= 0 && n < MH && hist[i] == hist[hist.size()-1]; i--) n++;
      return n;
   endfunction

   task automatic eval();
      int l, s;
      @(negedge clk);
      l = m_last();
      s = m_streak();
      cur_g = -1;
      if (!rst) begin
         if (bus.m0_req && bus.m1_req) cur_g = (s > 0 && s < MH) ? l : 1 - l;
         else if (bus.m0_req) cur_g = 0;
         else if (bus.m1_req) cur_g = 1;
      end
      cur_we0 = bus.m0_we;
      cur_we1 = bus.m1_we;
      chk("m0_gnt", bus.m0_gnt, cur_g == 0);
      chk("m1_gnt", bus.m1_gnt, cur_g == 1);
      chk("hold_q", dut.hold_q, s);
      chk("last_q", dut.last_q, l);
      chk("mem_addr", bus.mem_addr, cur_g == 0 ? bus.m0_addr : cur_g == 1 ? bus.m1_addr : 0);
      chk("mem_wdata", bus.mem_wdata, cur_g == 0 ? bus.m0_wdata : cur_g == 1 ? bus.m1_wdata : 0);
      chk("mem_we", bus.mem_we, cur_g == 0 ? bus.m0_we : cur_g == 1 ? bus.m1_we : 0);
      chk("mem_be", bus.mem_be, cur_g == 0 ? bus.m0_be : cur_g == 1 ? bus.m1_be : 0);
      chk("m0_rvalid", bus.m0_rvalid, exp_rv[0] != 0 && !rst);
      chk("m1_rvalid", bus.m1_rvalid, exp_rv[1] != 0 && !rst);
      chk("m0_rdata", bus.m0_rdata, bus.mem_rdata);
      chk("m1_rdata", bus.m1_rdata, bus.mem_rdata);
   endtask

   task automatic adv();
      @(posedge clk);
      if (rst) begin
         hist.delete();
         exp_rv = '{0, 0};
      end else begin
         hist.push_back(cur_g);
         exp_rv[0] = (cur_g == 0 && !cur_we0) ? 1 : 0;
         exp_rv[1] = (cur_g == 1 && !cur_we1) ? 1 : 0;
      end
      #1;
   endtask

   task automatic set_m(input int m, input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] be);
      if (m == 0) begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_be = be;
      end else begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_be = be;
      end
   endtask

   initial begin
      logic p0, p1;
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0, 0);
      bus.mem_rdata = '0;
      exp_rv = '{0, 0};
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      tab[0] = '{1'b1, 2'b11, 2'b00, 0};
      for (int i = 0; i < 12; i++)
         tab[i+1] = '{1'b0, 2'b11, ((i / 4) % 2) ? 2'b10 : 2'b01, i == 0 ? 0 : ((i - 1) % 4) + 1};
      tab[13] = '{1'b0, 2'b00, 2'b00, 4};
      tab[14] = '{1'b0, 2'b10, 2'b10, 0};
      tab[15] = '{1'b0, 2'b11, 2'b10, 1};
      tab[16] = '{1'b0, 2'b11, 2'b10, 2};
      tab[17] = '{1'b0, 2'b01, 2'b01, 3};
      tab[18] = '{1'b0, 2'b11, 2'b01, 1};
      for (int i = 0; i < 19; i++) begin
         rst = tab[i].r;
         set_m(0, tab[i].req[0], 1'b1, 32'h100 + i, 32'hA000 + i, 4'hF);
         set_m(1, tab[i].req[1], 1'b1, 32'h200 + i, 32'hB000 + i, 4'h5);
         bus.mem_rdata = $urandom;
         eval();
         chk($sformatf("tab%0d_gnt", i), {bus.m1_gnt, bus.m0_gnt}, tab[i].gnt);
         chk($sformatf("tab%0d_hold", i), dut.hold_q, tab[i].hold);
         if (tab[i].r) chk("rst_mem_we_be", {bus.mem_we, bus.mem_be}, 0);
         adv();
      end

      rst = 1'b1;
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0, 0);
      eval(); adv();
      rst = 1'b0;
      set_m(0, 1, 0, 32'h10, 0, 4'hF);
      eval();
      chk("rd_gnt", bus.m0_gnt, 1);
      chk("rd_addr", bus.mem_addr, 32'h10);
      adv();
      set_m(0, 0, 0, 0, 0, 0);
      bus.mem_rdata = 32'h00500113;
      eval();
      chk("rd_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b01);
      chk("rd_rdata", bus.m0_rdata, 32'h00500113);
      adv();
      eval();
      chk("rd_rvalid_once", bus.m0_rvalid, 0);
      adv();

      set_m(1, 1, 1, 32'h20, 32'hDEADBEEF, 4'b0011);
      eval();
      chk("wr_gnt", bus.m1_gnt, 1);
      chk("wr_mem", {bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr[7:0]}, {1'b1, 4'b0011, 32'hDEADBEEF, 8'h20});
      adv();
      set_m(1, 0, 0, 0, 0, 0);
      eval();
      chk("wr_no_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 0);
      adv();

      set_m(0, 1, 0, 32'h44, 0, 4'hF);
      eval();
      chk("rstrd_gnt", bus.m0_gnt, 1);
      adv();
      set_m(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      eval();
      chk("rstrd_rvalid", bus.m0_rvalid, 0);
      adv();
      rst = 1'b0;
      eval();
      chk("rstrd_state", {dut.last_q, dut.hold_q}, {1'b1, 3'd0});
      adv();

      p0 = 1'b1;
      p1 = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         if (!bus.m0_req || p0)
            set_m(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom));
         if (!bus.m1_req || p1)
            set_m(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom));
         bus.mem_rdata = $urandom;
         eval();
         p0 = bus.m0_gnt;
         p1 = bus.m1_gnt;
         adv();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end
endmodule
